// File: rtl/mult_arbiter_seq.sv
// mult_arbiter_seq: round-robin front end for two requesters sharing one shift-add multiplier.
// Optional feature macro MULT_EARLY_DONE_EN: retire an op once the remaining multiplier bits are zero.
module mult_arbiter_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               req0,
  input  logic [WIDTH-1:0]   a0,
  input  logic [WIDTH-1:0]   b0,
  input  logic               req1,
  input  logic [WIDTH-1:0]   a1,
  input  logic [WIDTH-1:0]   b1,
  output logic               gnt0,
  output logic               gnt1,
  output logic               busy,
  output logic               done,
  output logic               done_id,
  output logic [2*WIDTH-1:0] product
);
  localparam int PW = 2*WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             id;
  } op_t;

  state_t           state, state_nxt;
  op_t              op, req_op;
  logic [PW-1:0]    acc, acc_nxt, pp;
  logic [CNT_W-1:0] cnt;
  logic             prio, win, accept, last_step;

  // prio names the requester preferred on a tie; it flips to the loser after each accept.
  assign win = req1 && (!req0 || prio);

  always_comb begin
    req_op    = win ? op_t'{a: a1, b: b1, id: 1'b1} : op_t'{a: a0, b: b0, id: 1'b0};
    pp        = op.b[cnt] ? (PW'(op.a) << cnt) : '0;
    acc_nxt   = acc + pp;
    last_step = (cnt == CNT_W'(WIDTH-1));
`ifdef MULT_EARLY_DONE_EN
    if (((op.b >> cnt) >> 1) == '0) last_step = 1'b1;
`endif
    accept    = 1'b0;
    state_nxt = state;
    case (state)
      S_IDLE: if (req0 || req1) begin
        accept    = 1'b1;
        state_nxt = S_RUN;
      end
      S_RUN:  if (last_step) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= S_IDLE;
      op      <= '0;
      acc     <= '0;
      cnt     <= '0;
      prio    <= 1'b0;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      done_id <= 1'b0;
      // An aborted op leaves the last result visible; an idle reset clears it.
      if (!busy) product <= '0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != S_IDLE);
      gnt0  <= accept && !req_op.id;
      gnt1  <= accept && req_op.id;
      done  <= 1'b0;
      if (accept) begin
        op   <= req_op;
        acc  <= '0;
        cnt  <= '0;
        prio <= ~req_op.id;
      end
      if (state == S_RUN) begin
        acc <= acc_nxt;
        cnt <= cnt + CNT_W'(1);
        if (last_step) begin
          product <= acc_nxt;
          done    <= 1'b1;
          done_id <= op.id;
        end
      end
    end
  end
endmodule

// File: tb/tb_mult_arbiter_seq.sv
// Self-checking bench for mult_arbiter_seq: directed scenarios plus a randomized scoreboard run.
module tb_mult_arbiter_seq;
  localparam int W  = 8;
  localparam int PW = 2*W;
`ifdef MULT_EARLY_DONE_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic          CLK = 1'b0, RESET = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic [W-1:0]  a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic          gnt0, gnt1, busy, done, done_id;
  logic [PW-1:0] product;
  int            checks = 0, errors = 0;
  int            cyc = 0;
  logic [PW-1:0] last_prod = '0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  mult_arbiter_seq #(.WIDTH(W), .CNT_W(3)) dut (
    .CLK(CLK), .RESET(RESET),
    .req0(req0), .a0(a0), .b0(b0),
    .req1(req1), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done), .done_id(done_id),
    .product(product)
  );

  // Gnt-to-done cycles from the spec: WIDTH, or highest set bit of b plus one when retiring early.
  function automatic int exp_lat(input logic [W-1:0] b);
    int hi = 0;
    for (int i = 0; i < W; i++) if (b[i]) hi = i;
    return EARLY ? hi + 1 : W;
  endfunction

  function automatic logic [PW-1:0] mul(input logic [W-1:0] a, input logic [W-1:0] b);
    return PW'(a) * PW'(b);
  endfunction

  // Drives one single-requester op and measures it; callers do the comparisons.
  task automatic do_op(input bit id, input logic [W-1:0] a, input logic [W-1:0] b,
                       output bit ok, output int lat, output int bcnt,
                       output logic [PW-1:0] p, output logic pid);
    bit got = 0;
    ok = 0; lat = 0; bcnt = 0; p = '0; pid = 1'b0;
    @(negedge CLK);
    if (id) begin req1 = 1; a1 = a; b1 = b; end
    else    begin req0 = 1; a0 = a; b0 = b; end
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge CLK);
      if (id ? gnt1 : gnt0) got = 1;
    end
    if (id) begin req1 = 0; a1 = W'($urandom); b1 = W'($urandom); end
    else    begin req0 = 0; a0 = W'($urandom); b0 = W'($urandom); end
    if (!got) return;
    if (busy) bcnt++;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge CLK);
      lat++;
      if (busy) bcnt++;
      if (done) begin got = 1; p = product; pid = done_id; end
    end
    ok = got;
  endtask

  task automatic pulse_reset();
    @(negedge CLK);
    RESET = 1; req0 = 0; req1 = 0;
    repeat (2) @(negedge CLK);
    RESET = 0;
  endtask

  task automatic test_reset();
    RESET = 1;
    repeat (3) @(negedge CLK);
    checks++;
    if ({gnt0, gnt1, busy, done, done_id} !== 5'b0 || product !== '0) begin
      errors++;
      $display("FAIL reset_state got ctl=%b product=%h want ctl=00000 product=0",
               {gnt0, gnt1, busy, done, done_id}, product);
    end
    RESET = 0;
    repeat (2) @(negedge CLK);
    checks++;
    if ({gnt0, gnt1, busy, done} !== 4'b0) begin
      errors++;
      $display("FAIL idle_no_req got ctl=%b want 0000", {gnt0, gnt1, busy, done});
    end
    last_prod = '0;
  endtask

  task automatic test_basic();
    bit ok; int lat, bc; logic [PW-1:0] p; logic pid;
    do_op(0, 8'd3, 8'd5, ok, lat, bc, p, pid);
    checks++;
    if (!ok || p !== 16'd15 || pid !== 1'b0 || lat != exp_lat(8'd5)) begin
      errors++;
      $display("FAIL basic_3x5 got ok=%0b p=%0d id=%b lat=%0d want p=15 id=0 lat=%0d",
               ok, p, pid, lat, exp_lat(8'd5));
    end
    @(negedge CLK);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || product !== 16'd15) begin
      errors++;
      $display("FAIL basic_after got done=%b busy=%b p=%0d want done=0 busy=0 p=15", done, busy, product);
    end
    last_prod = 16'd15;
  endtask

  task automatic test_max();
    bit ok; int lat, bc; logic [PW-1:0] p; logic pid;
    do_op(1, 8'd255, 8'd255, ok, lat, bc, p, pid);
    checks++;
    if (!ok || p !== 16'hFE01 || pid !== 1'b1) begin
      errors++;
      $display("FAIL max_operands got ok=%0b p=%h id=%b want p=fe01 id=1", ok, p, pid);
    end
    checks++;
    if (bc != exp_lat(8'd255) + 1) begin
      errors++;
      $display("FAIL max_busy_len got %0d want %0d", bc, exp_lat(8'd255) + 1);
    end
    last_prod = 16'hFE01;
  endtask

  task automatic test_both_held();
    logic [W-1:0] ta[2], tb[2];
    int gc[4]; bit gi[4]; bit di[4]; logic [PW-1:0] dp[4];
    int ng = 0, nd = 0; bit ovl = 0;
    pulse_reset();
    for (int k = 0; k < 2; k++) begin ta[k] = W'($urandom); tb[k] = W'($urandom); end
    @(negedge CLK);
    req0 = 1; req1 = 1; a0 = ta[0]; b0 = tb[0]; a1 = ta[1]; b1 = tb[1];
    for (int i = 0; i < 200 && nd < 4; i++) begin
      @(negedge CLK);
      if ((gnt0 || gnt1) && done) ovl = 1;
      if ((gnt0 || gnt1) && ng < 4) begin gc[ng] = cyc; gi[ng] = gnt1; ng++; end
      if (done) begin di[nd] = done_id; dp[nd] = product; nd++; end
    end
    req0 = 0; req1 = 0;
    checks++;
    if (ng != 4 || nd != 4) begin
      errors++;
      $display("FAIL both_timeout got grants=%0d dones=%0d want 4 4", ng, nd);
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (gi[k] !== k[0] || di[k] !== k[0] || dp[k] !== mul(ta[k%2], tb[k%2])) begin
          errors++;
          $display("FAIL both_order_%0d got gnt=%0b id=%0b p=%h want %0b %0b %h",
                   k, gi[k], di[k], dp[k], k[0], k[0], mul(ta[k%2], tb[k%2]));
        end
        if (k > 0) begin
          checks++;
          if (gc[k] - gc[k-1] != exp_lat(tb[(k-1)%2]) + 2) begin
            errors++;
            $display("FAIL both_spacing_%0d got %0d want %0d", k, gc[k] - gc[k-1], exp_lat(tb[(k-1)%2]) + 2);
          end
        end
      end
    end
    checks++;
    if (ovl) begin
      errors++;
      $display("FAIL gnt_done_overlap got 1 want 0");
    end
    repeat (W + 4) @(negedge CLK);
    last_prod = dp[3];
  endtask

  task automatic test_late_req();
    logic [W-1:0] xa = W'($urandom), xb = W'($urandom) | 8'h80;
    logic [W-1:0] ya = W'($urandom), yb = W'($urandom);
    int g0 = -1, g1 = -1; bit early_g1 = 0, got_d = 0;
    logic [PW-1:0] p = '0; logic pid = 1'b0;
    @(negedge CLK);
    req0 = 1; a0 = xa; b0 = xb;
    for (int i = 0; i < 40 && g0 < 0; i++) begin
      @(negedge CLK);
      if (gnt0) g0 = cyc;
    end
    req0 = 0;
    repeat (3) @(negedge CLK);
    req1 = 1; a1 = ya; b1 = yb;
    for (int i = 0; i < 40 && g1 < 0; i++) begin
      @(negedge CLK);
      if (gnt1) begin g1 = cyc; if (busy && done) early_g1 = 1; end
    end
    req1 = 0; a1 = '0; b1 = '0;
    for (int i = 0; i < 40 && !got_d; i++) begin
      @(negedge CLK);
      if (done) begin got_d = 1; p = product; pid = done_id; end
    end
    checks++;
    if (g0 < 0 || g1 - g0 != exp_lat(xb) + 2 || early_g1) begin
      errors++;
      $display("FAIL late_req_wait got gnt0@%0d gnt1@%0d want gap %0d", g0, g1, exp_lat(xb) + 2);
    end
    checks++;
    if (!got_d || p !== mul(ya, yb) || pid !== 1'b1) begin
      errors++;
      $display("FAIL late_req_result got p=%h id=%b want p=%h id=1", p, pid, mul(ya, yb));
    end
    last_prod = mul(ya, yb);
  endtask

  task automatic test_reset_abort();
    bit got = 0, spur = 0; bit ok; int lat, bc; logic [PW-1:0] p; logic pid;
    @(negedge CLK);
    req0 = 1; a0 = W'($urandom); b0 = W'($urandom) | 8'h80;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge CLK);
      if (gnt0) got = 1;
    end
    req0 = 0;
    repeat (3) @(negedge CLK);
    RESET = 1;
    @(negedge CLK);
    checks++;
    if (!got || busy !== 1'b0 || done !== 1'b0 || product !== last_prod) begin
      errors++;
      $display("FAIL abort_state got busy=%b done=%b p=%h want busy=0 done=0 p=%h", busy, done, product, last_prod);
    end
    RESET = 0;
    repeat (W + 2) begin
      @(negedge CLK);
      if (done || busy) spur = 1;
    end
    checks++;
    if (spur || product !== last_prod) begin
      errors++;
      $display("FAIL abort_quiet got spur=%0b p=%h want spur=0 p=%h", spur, product, last_prod);
    end
    do_op(0, 8'd7, 8'd9, ok, lat, bc, p, pid);
    checks++;
    if (!ok || p !== 16'd63 || pid !== 1'b0 || lat != exp_lat(8'd9)) begin
      errors++;
      $display("FAIL abort_next_op got p=%0d id=%b lat=%0d want p=63 id=0 lat=%0d", p, pid, lat, exp_lat(8'd9));
    end
    last_prod = 16'd63;
  endtask

  task automatic test_early_done();
    bit ok; int lat, bc; logic [PW-1:0] p; logic pid;
    do_op(0, 8'd200, 8'd1, ok, lat, bc, p, pid);
    checks++;
    if (!ok || p !== 16'd200 || lat != (EARLY ? 1 : W)) begin
      errors++;
      $display("FAIL early_done got p=%0d lat=%0d want p=200 lat=%0d", p, lat, EARLY ? 1 : W);
    end
    do_op(1, 8'd123, 8'd0, ok, lat, bc, p, pid);
    checks++;
    if (!ok || p !== 16'd0 || pid !== 1'b1 || lat != (EARLY ? 1 : W)) begin
      errors++;
      $display("FAIL zero_operand got p=%0d id=%b lat=%0d want p=0 id=1 lat=%0d", p, pid, lat, EARLY ? 1 : W);
    end
    last_prod = '0;
  endtask

  task automatic test_random();
    bit pref = 0;
    pulse_reset();
    for (int it = 0; it < 24; it++) begin
      int mode = int'($urandom_range(0, 2));
      logic [W-1:0] ra0 = W'($urandom), rb0 = W'($urandom), ra1 = W'($urandom), rb1 = W'($urandom);
      if (it % 4 == 0) rb0 = W'(1) << $urandom_range(0, W-1);
      if (mode < 2) begin
        bit ok; int lat, bc; logic [PW-1:0] p; logic pid;
        bit id = mode[0];
        logic [W-1:0] xa = id ? ra1 : ra0, xb = id ? rb1 : rb0;
        do_op(id, xa, xb, ok, lat, bc, p, pid);
        checks++;
        if (!ok || p !== mul(xa, xb) || pid !== id || lat != exp_lat(xb)) begin
          errors++;
          $display("FAIL rand_single_%0d got p=%h id=%b lat=%0d want p=%h id=%b lat=%0d",
                   it, p, pid, lat, mul(xa, xb), id, exp_lat(xb));
        end
        pref = ~id;
      end else begin
        bit got = 0, w = 0, gd = 0; int lat = 0; logic [PW-1:0] p = '0; logic pid = 1'b0;
        @(negedge CLK);
        req0 = 1; req1 = 1; a0 = ra0; b0 = rb0; a1 = ra1; b1 = rb1;
        for (int i = 0; i < 40 && !got; i++) begin
          @(negedge CLK);
          if (gnt0 || gnt1) begin got = 1; w = gnt1; end
        end
        req0 = 0; req1 = 0;
        for (int i = 0; i < 40 && !gd; i++) begin
          @(negedge CLK);
          lat++;
          if (done) begin gd = 1; p = product; pid = done_id; end
        end
        checks++;
        if (!got || !gd || w !== pref || pid !== pref ||
            p !== mul(pref ? ra1 : ra0, pref ? rb1 : rb0) || lat != exp_lat(pref ? rb1 : rb0)) begin
          errors++;
          $display("FAIL rand_both_%0d got w=%b id=%b p=%h lat=%0d want w=%b p=%h lat=%0d",
                   it, w, pid, p, lat, pref, mul(pref ? ra1 : ra0, pref ? rb1 : rb0), exp_lat(pref ? rb1 : rb0));
        end
        pref = ~pref;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_both_held();
    test_late_req();
    test_reset_abort();
    test_early_done();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
